// File: rtl/line_step_ctrl_if.sv
// Bundles the line-walk controller's launch, subtractor and pixel signals.
// master: controller side (drives sub_a/sub_b, busy, pixel bus, done).
// slave: surrounding core (drives start, endpoints, sub_result, pix_ready).
interface line_step_ctrl_if #(
   parameter int WIDTH = 13
);
   logic                    start;
   logic signed [WIDTH-1:0] x0;
   logic signed [WIDTH-1:0] y0;
   logic signed [WIDTH-1:0] x1;
   logic signed [WIDTH-1:0] y1;
   logic signed [WIDTH-1:0] sub_a;
   logic signed [WIDTH-1:0] sub_b;
   logic signed [WIDTH-1:0] sub_result;
   logic                    busy;
   logic                    pix_valid;
   logic                    pix_ready;
   logic signed [WIDTH-1:0] pix_x;
   logic signed [WIDTH-1:0] pix_y;
   logic                    done;

   modport master (
      input  start, x0, y0, x1, y1, sub_result, pix_ready,
      output sub_a, sub_b, busy, pix_valid, pix_x, pix_y, done
   );

   modport slave (
      output start, x0, y0, x1, y1, sub_result, pix_ready,
      input  sub_a, sub_b, busy, pix_valid, pix_x, pix_y, done
   );
endinterface

// File: rtl/line_step_ctrl.sv
// Bresenham line walker: sequences the shared subtractor for dx/dy, then emits one pixel per cycle.
// Latency: first pixel 4 cycles after the accepted start; done pulses the cycle after the last pixel.
// Backpressure: pix_ready low holds the current pixel and error term; pix_valid never drops without a transfer.
//
// Ports: clk, rst (async, active-high); lif (master) carries start, endpoints x0/y0/x1/y1,
// subtractor operands sub_a/sub_b and sub_result, busy, pix_valid/pix_ready/pix_x/pix_y, done.
// Optional build macro LINE_CLIP_EN: points with a negative coordinate are skipped (not presented).
module line_step_ctrl #(
   parameter int WIDTH = 13
) (
   input logic             clk,
   input logic             rst,
   line_step_ctrl_if.master lif
);
   localparam int EW = WIDTH + 2;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SDX  = 3'd1;
   localparam logic [2:0] S_SDY  = 3'd2;
   localparam logic [2:0] S_INIT = 3'd3;
   localparam logic [2:0] S_EMIT = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic signed [WIDTH-1:0] ONE = 1;

   logic [2:0]              state;
   logic signed [WIDTH-1:0] x0_q, y0_q, x1_q, y1_q;
   logic signed [WIDTH-1:0] dx_raw, dy_raw;
   logic signed [WIDTH-1:0] cur_x, cur_y;
   logic signed [EW-1:0]    dx, dy, err;
   logic                    sx_neg, sy_neg;

   logic signed [EW-1:0]    dx_abs, dy_abs, e2, err_nxt;
   logic signed [WIDTH-1:0] x_nxt, y_nxt;
   logic                    at_end, clipped, show, advance;

   always_comb begin
      dx_abs = {{2{dx_raw[WIDTH-1]}}, dx_raw};
      dy_abs = {{2{dy_raw[WIDTH-1]}}, dy_raw};
      if (dx_raw[WIDTH-1]) dx_abs = -dx_abs;
      if (dy_raw[WIDTH-1]) dy_abs = -dy_abs;

      // Both axis decisions look at the pre-step error, so they are
      // evaluated from err/e2 and accumulated into err_nxt independently.
      e2      = err <<< 1;
      err_nxt = err;
      x_nxt   = cur_x;
      y_nxt   = cur_y;
      if (e2 >= dy) begin
         err_nxt = err_nxt + dy;
         x_nxt   = sx_neg ? cur_x - ONE : cur_x + ONE;
      end
      if (e2 <= dx) begin
         err_nxt = err_nxt + dx;
         y_nxt   = sy_neg ? cur_y - ONE : cur_y + ONE;
      end

      at_end = (cur_x == x1_q) && (cur_y == y1_q);
`ifdef LINE_CLIP_EN
      clipped = cur_x[WIDTH-1] | cur_y[WIDTH-1];
`else
      clipped = 1'b0;
`endif
      show    = (state == S_EMIT) && !clipped;
      // A clipped point is never presented, so it must not wait for pix_ready.
      advance = (state == S_EMIT) && (clipped || lif.pix_ready);
   end

   // Outputs decode from state so that reset zeroes them immediately.
   always_comb begin
      lif.sub_a     = '0;
      lif.sub_b     = '0;
      if (state == S_SDX) begin
         lif.sub_a = x1_q;
         lif.sub_b = x0_q;
      end else if (state == S_SDY) begin
         lif.sub_a = y1_q;
         lif.sub_b = y0_q;
      end
      lif.busy      = (state != S_IDLE);
      lif.done      = (state == S_DONE);
      lif.pix_valid = show;
      lif.pix_x     = show ? cur_x : '0;
      lif.pix_y     = show ? cur_y : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         x0_q   <= '0;
         y0_q   <= '0;
         x1_q   <= '0;
         y1_q   <= '0;
         dx_raw <= '0;
         dy_raw <= '0;
         cur_x  <= '0;
         cur_y  <= '0;
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         sx_neg <= 1'b0;
         sy_neg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (lif.start) begin
                  x0_q  <= lif.x0;
                  y0_q  <= lif.y0;
                  x1_q  <= lif.x1;
                  y1_q  <= lif.y1;
                  state <= S_SDX;
               end
            end
            S_SDX: begin
               dx_raw <= lif.sub_result;
               state  <= S_SDY;
            end
            S_SDY: begin
               dy_raw <= lif.sub_result;
               state  <= S_INIT;
            end
            S_INIT: begin
               sx_neg <= dx_raw[WIDTH-1];
               sy_neg <= dy_raw[WIDTH-1];
               dx     <= dx_abs;
               dy     <= -dy_abs;
               err    <= dx_abs - dy_abs;
               cur_x  <= x0_q;
               cur_y  <= y0_q;
               state  <= S_EMIT;
            end
            S_EMIT: begin
               if (advance) begin
                  if (at_end) begin
                     state <= S_DONE;
                  end else begin
                     cur_x <= x_nxt;
                     cur_y <= y_nxt;
                     err   <= err_nxt;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_line_step_ctrl.sv
module tb_line_step_ctrl;
   localparam int W = 13;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   line_step_ctrl_if #(.WIDTH(W)) lif ();

   line_step_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .lif (lif)
   );

   // External subtractor: true difference, low bits kept, sign from bit WIDTH.
   logic signed [W:0] full_diff;
   assign full_diff      = {lif.sub_a[W-1], lif.sub_a} - {lif.sub_b[W-1], lif.sub_b};
   assign lif.sub_result = {full_diff[W], full_diff[W-2:0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch at the current cycle (accepted at the next edge) and check SDX/SDY/INIT.
   // Returns positioned in cycle 4 (first EMIT cycle).
   task automatic launch(input int ax0, input int ay0, input int ax1, input int ay1);
      lif.x0    = W'(ax0);
      lif.y0    = W'(ay0);
      lif.x1    = W'(ax1);
      lif.y1    = W'(ay1);
      lif.start = 1'b1;
      step();
      lif.start = 1'b0;
      chk("sdx_busy", 32'(lif.busy), 32'd1);
      chk("sdx_sub_a", 32'(lif.sub_a), 32'(ax1));
      chk("sdx_sub_b", 32'(lif.sub_b), 32'(ax0));
      chk("sdx_valid", 32'(lif.pix_valid), 32'd0);
      step();
      chk("sdy_sub_a", 32'(lif.sub_a), 32'(ay1));
      chk("sdy_sub_b", 32'(lif.sub_b), 32'(ay0));
      step();
      chk("init_sub_a", 32'(lif.sub_a), 32'd0);
      chk("init_valid", 32'(lif.pix_valid), 32'd0);
      step();
   endtask

   task automatic pix(input int ex, input int ey);
      chk("pix_valid", 32'(lif.pix_valid), 32'd1);
      chk("pix_x", 32'(lif.pix_x), 32'(ex));
      chk("pix_y", 32'(lif.pix_y), 32'(ey));
      chk("pix_busy", 32'(lif.busy), 32'd1);
      chk("pix_done", 32'(lif.done), 32'd0);
      step();
   endtask

   task automatic fin();
      chk("done_pulse", 32'(lif.done), 32'd1);
      chk("done_busy", 32'(lif.busy), 32'd1);
      chk("done_valid", 32'(lif.pix_valid), 32'd0);
      step();
      chk("idle_busy", 32'(lif.busy), 32'd0);
      chk("idle_done", 32'(lif.done), 32'd0);
   endtask

   initial begin
      rst           = 1'b1;
      lif.start     = 1'b0;
      lif.x0        = '0;
      lif.y0        = '0;
      lif.x1        = '0;
      lif.y1        = '0;
      lif.pix_ready = 1'b1;
      #1;
      chk("rst_busy", 32'(lif.busy), 32'd0);
      chk("rst_valid", 32'(lif.pix_valid), 32'd0);
      chk("rst_done", 32'(lif.done), 32'd0);
      chk("rst_sub_a", 32'(lif.sub_a), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // Basic line; a start raised mid-line must be ignored.
      launch(0, 0, 3, 1);
      pix(0, 0);
      lif.start = 1'b1;
      lif.x0    = W'(7);
      lif.x1    = W'(9);
      pix(1, 0);
      lif.start = 1'b0;
      pix(2, 1);
      pix(3, 1);
      fin();
      step();

      // Reverse diagonal.
      launch(3, 3, 0, 0);
      pix(3, 3);
      pix(2, 2);
      pix(1, 1);
      pix(0, 0);
      fin();

      // Single point; start held through the done cycle is taken only once idle.
      launch(5, 5, 5, 5);
      pix(5, 5);
      lif.x0    = W'(9);
      lif.y0    = W'(1);
      lif.x1    = W'(9);
      lif.y1    = W'(1);
      lif.start = 1'b1;
      chk("sp_done", 32'(lif.done), 32'd1);
      chk("sp_busy5", 32'(lif.busy), 32'd1);
      step();
      chk("sp_busy6", 32'(lif.busy), 32'd0);
      chk("sp_done6", 32'(lif.done), 32'd0);
      step();
      lif.start = 1'b0;
      chk("relaunch_busy", 32'(lif.busy), 32'd1);
      chk("relaunch_sub_a", 32'(lif.sub_a), 32'd9);
      step();
      step();
      step();
      pix(9, 1);
      fin();

      // Backpressure on the second pixel for three cycles.
      launch(0, 0, 3, 1);
      pix(0, 0);
      lif.pix_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pix(1, 0);
      end
      lif.pix_ready = 1'b1;
      pix(1, 0);
      pix(2, 1);
      pix(3, 1);
      fin();

      // Reset during the third pixel, then a fresh steep line.
      launch(0, 0, 3, 1);
      pix(0, 0);
      pix(1, 0);
      chk("pre_rst_x", 32'(lif.pix_x), 32'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(lif.pix_valid), 32'd0);
      chk("mid_rst_busy", 32'(lif.busy), 32'd0);
      chk("mid_rst_x", 32'(lif.pix_x), 32'd0);
      chk("mid_rst_y", 32'(lif.pix_y), 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_done", 32'(lif.done), 32'd0);
         chk("post_rst_busy", 32'(lif.busy), 32'd0);
         step();
      end
      launch(1, 2, 2, 4);
      pix(1, 2);
      pix(2, 3);
      pix(2, 4);
      fin();

      // Negative coordinates.
`ifdef LINE_CLIP_EN
      launch(-2, 0, 1, 0);
      lif.pix_ready = 1'b0;
      chk("clip_v4", 32'(lif.pix_valid), 32'd0);
      step();
      chk("clip_v5", 32'(lif.pix_valid), 32'd0);
      step();
      lif.pix_ready = 1'b1;
      pix(0, 0);
      pix(1, 0);
      fin();
`else
      launch(-2, 0, 1, 0);
      pix(-2, 0);
      pix(-1, 0);
      pix(0, 0);
      pix(1, 0);
      fin();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/line_step_ctrl.md
# line_step_ctrl

Bresenham line-walk controller for the line-drawing core. It accepts one pair of signed endpoints and sequences the core's shared external signed subtraction unit to compute dx and dy. It then walks the line and emits one pixel coordinate per cycle to the rasteriser back end over a valid/ready handshake. It owns the subtractor's operand inputs while busy and is the only block that drives them.

## Interface
- WIDTH, 13, coordinate and subtractor width (signed two's complement)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  launch request; sampled only in IDLE
- x0, y0, x1, y1  in  WIDTH each  signed endpoints; captured on the accepted start
- sub_a, sub_b  out  WIDTH each  operands to the external subtractor
- sub_result  in  WIDTH  subtractor result, combinational from sub_a/sub_b
- busy  out  1  high from the accepted start until done
- pix_valid  out  1  pix_x/pix_y hold a pixel
- pix_ready  in  1  back end accepts the pixel
- pix_x, pix_y  out  WIDTH each  pixel coordinate
- done  out  1  one-cycle pulse when the line completes

## Operation
- **Reset values:** state IDLE; all outputs 0.
- **States:**
  - IDLE: on start=1, capture the endpoints, set busy, go to SDX.
  - SDX: sub_a=x1, sub_b=x0; register dx_raw=sub_result; go to SDY.
  - SDY: sub_a=y1, sub_b=y0; register dy_raw; go to INIT.
  - INIT: sx=+1 if dx_raw≥0, else −1; sy likewise from dy_raw. dx=|dx_raw|, dy=−|dy_raw|, err=dx+dy. Current point = (x0,y0). Go to EMIT.
  - EMIT: pix_valid=1 with the current point.
    - On pix_ready: if the current point equals (x1,y1), go to DONE. Otherwise apply the step and stay in EMIT.
    - Step: e2=2·err. If e2≥dy: err+=dy, x+=sx. If e2≤dx: err+=dx, y+=sy. Both updates use the pre-step err and may apply in the same cycle.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- **sub_a/sub_b** are 0 outside SDX/SDY.
- **Subtractor behaviour:** it returns the true difference truncated to WIDTH bits, with the sign taken from bit WIDTH of the full result. Any endpoint difference must satisfy |diff| ≤ 2^(WIDTH−1)−1 (4095 for WIDTH=13). Outside this range the output is undefined; no detection is required.
- **Internal widths:** err and e2 are WIDTH+2 bits signed, so they never overflow within the legal range.
- **start while busy** is ignored; no queueing.
- **Degenerate line** (x0,y0)=(x1,y1): exactly one pixel, then done.

## Timing
- start accepted at edge 0. SDX runs in cycle 1, SDY in cycle 2, INIT in cycle 3. The first pix_valid is high in cycle 4.
- With pix_ready held high: one pixel per cycle, N pixels in cycles 4..N+3, done in cycle N+4, busy low from cycle N+5.
- **Backpressure:** while pix_valid=1 and pix_ready=0, pix_x, pix_y and err are held stable. pix_valid never drops without a handshake.
- The pixel transfers on a cycle where pix_valid and pix_ready are both high.
- **Reset mid-line:** immediate return to IDLE, all outputs 0, the partial line is discarded, and there is no done pulse.
- start may be asserted in the cycle done is high. It is ignored until IDLE, i.e. the earliest new launch is accepted one cycle after done.

## Configuration
- **LINE_CLIP_EN defined:** points with pix_x<0 or pix_y<0 are not presented; pix_valid stays low for them. The walker still advances one point per cycle without waiting for pix_ready. The final point is skipped the same way if negative, and done still pulses.
- **LINE_CLIP_EN undefined:** every point is presented, including negative coordinates.

## Test plan
- **Basic line:** (0,0)→(3,1), pix_ready=1 → pixels (0,0),(1,0),(2,1),(3,1) in cycles 4–7; done in cycle 8.
- **Reverse diagonal:** (3,3)→(0,0) → (3,3),(2,2),(1,1),(0,0); sub_a=0, sub_b=3 in SDX.
- **Single point:** (5,5)→(5,5) → one pixel (5,5), then done; busy high for exactly 5 cycles.
- **Backpressure:** pix_ready low for 3 cycles on the second pixel of (0,0)→(3,1) → (1,0) held stable, no pixel lost or duplicated, done delayed by 3 cycles.
- **Reset mid-line:** rst asserted during the third pixel → outputs 0 next cycle, no done. A new start then walks correctly from scratch.
- **Clipping:** (−2,0)→(1,0):
  - LINE_CLIP_EN defined: only (0,0),(1,0) are presented.
  - LINE_CLIP_EN undefined: (−2,0),(−1,0),(0,0),(1,0) are presented.
